sd_clock_monitor: RTL

Card-side companion to the host SD clock divider. It samples the incoming SD_CLK in the local CLK domain and emits single-cycle RISE/FALL strobes for the card command/data shifters. It measures the half-period in CLK cycles and reports the equivalent 8-bit divider value once the clock is stable. It flags a stopped SD clock.

---
 rtl/sd_clock_monitor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sd_clock_monitor.sv
// Card-side SD_CLK monitor: synchronizes SD_CLK, emits RISE/FALL strobes,
// measures the half-period to estimate the host divider, and flags a stopped clock.
module sd_clock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int STOP_LIMIT  = 511
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SD_CLK,
  output logic       RISE,
  output logic       FALL,
  output logic       CLK_LEVEL,
  output logic [7:0] DIV_EST,
  output logic       LOCKED,
  output logic       STOPPED
);

  typedef enum logic [2:0] {IDLE, ACQ, MEAS, LOCK, STOP} state_t;

  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES);
  localparam logic [8:0] STOP_CNT  = 9'(STOP_LIMIT);
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [8:0] MAX_HP    = 9'd256;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   primed_q, primed_d;
  logic [2:0]             fill_q, fill_d;
  logic [8:0]             hp_cnt_q, hp_cnt_d;
  logic [8:0]             ref_q, ref_d;
  logic [3:0]             match_q, match_d;
  logic [7:0]             div_est_q, div_est_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   locked_q, locked_d;
  logic                   stopped_q, stopped_d;

  logic       sd_level;
  logic       edge_det;
  logic       n_valid;
  logic       n_match;
  logic       stop_hit;
  logic [3:0] match_inc;
  logic [7:0] div_from_ref;
  logic [7:0] div_from_n;

  assign sd_level     = sync_q[SYNC_STAGES-1];
  assign edge_det     = EN && primed_q && (sd_level != prev_q);
  assign n_valid      = (hp_cnt_q <= MAX_HP);
  assign n_match      = n_valid && (hp_cnt_q == ref_q);
  assign stop_hit     = (hp_cnt_q >= STOP_CNT);
  assign match_inc    = match_q + 4'd1;
  assign div_from_ref = 8'(ref_q - 9'd1);
  assign div_from_n   = 8'(hp_cnt_q - 9'd1);

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], SD_CLK};
    prev_d    = sd_level;
    // Reset clears the chain, so priming waits until it has refilled with the
    // real SD_CLK level; otherwise a high SD_CLK at release would look like a rise.
    fill_d    = (fill_q == FILL_DONE) ? fill_q : fill_q + 3'd1;
    primed_d  = EN && (fill_q == FILL_DONE);
    state_d   = state_q;
    ref_d     = ref_q;
    match_d   = match_q;
    div_est_d = div_est_q;

    if (!EN)                  hp_cnt_d = 9'd0;
    else if (edge_det)        hp_cnt_d = 9'd1;
    else if (&hp_cnt_q)       hp_cnt_d = hp_cnt_q;
    else                      hp_cnt_d = hp_cnt_q + 9'd1;

    if (!EN) begin
      state_d = IDLE;
      ref_d   = 9'd0;
      match_d = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: if (edge_det) state_d = ACQ;
        ACQ: begin
          if (edge_det) begin
            state_d = MEAS;
            if (n_valid) begin
              ref_d   = hp_cnt_q;
              match_d = 4'd1;
              if (LOCK_N == 4'd1) begin
                state_d   = LOCK;
                div_est_d = div_from_n;
              end
            end else begin
              ref_d   = 9'd0;
              match_d = 4'd0;
            end
          end else if (stop_hit) begin
            state_d = STOP;
          end
        end
        MEAS: begin
          if (edge_det) begin
            if (n_match) begin
              match_d = match_inc;
              if (match_inc >= LOCK_N) begin
                state_d   = LOCK;
                div_est_d = div_from_ref;
              end
            end else if (n_valid) begin
              ref_d   = hp_cnt_q;
              match_d = 4'd1;
            end else begin
              ref_d   = 9'd0;
              match_d = 4'd0;
            end
          end else if (stop_hit) begin
            state_d = STOP;
          end
        end
        LOCK: begin
          if (edge_det) begin
            if (!n_match) begin
              state_d = MEAS;
              ref_d   = n_valid ? hp_cnt_q : 9'd0;
              match_d = n_valid ? 4'd1 : 4'd0;
            end
          end else if (stop_hit) begin
            state_d = STOP;
          end
        end
        STOP: if (edge_det) state_d = ACQ;
        default: state_d = IDLE;
      endcase
    end

    rise_d    = edge_det && sd_level;
    fall_d    = edge_det && !sd_level;
    locked_d  = (state_d == LOCK);
    stopped_d = (state_d == STOP);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      primed_q  <= 1'b0;
      fill_q    <= 3'd0;
      hp_cnt_q  <= 9'd0;
      ref_q     <= 9'd0;
      match_q   <= 4'd0;
      div_est_q <= 8'd0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      locked_q  <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      fill_q    <= fill_d;
      hp_cnt_q  <= hp_cnt_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      div_est_q <= div_est_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      locked_q  <= locked_d;
      stopped_q <= stopped_d;
    end
  end

  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign CLK_LEVEL = sd_level;
  assign DIV_EST   = div_est_q;
  assign LOCKED    = locked_q;
  assign STOPPED   = stopped_q;

endmodule
